// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLLRST = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RUN    = 3'd4,
        ST_FAIL   = 3'd5
    } seq_state_t;

    // Counter width needed to reach (largest count - 1); at least one bit.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c,
                                              input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the sequencer, the PLL and the PLL clock domain.
interface pll_lock_sequencer_if;
    logic       pll_lock;
    logic       pll_resetb;
    logic       sys_reset;
    logic       locked;
    logic       fail;
    logic [3:0] retries;

    modport master (
        input  pll_lock,
        output pll_resetb, sys_reset, locked, fail, retries
    );

    modport slave (
        output pll_lock,
        input  pll_resetb, sys_reset, locked, fail, retries
    );
endinterface

// File: rtl/pll_seq_sync.sv
// Two-flop synchroniser for the asynchronous PLL LOCK pin.
module pll_seq_sync (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);
    logic meta;

    // Shift the raw input through two flops; cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end
endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock qualification sequencer for an iCE40 SB_PLL40.
// Optional build macro PLL_SEQ_RELOCK_EN: loss of lock in RUN restarts the
// full sequence with a PLL reset pulse instead of re-qualifying lock.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT       = 65535,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RESET_HOLD_CYCLES  = 256,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    pll_lock_sequencer_if.master  bus
);
    localparam int unsigned CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT,
                                           LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);

    localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD_CYCLES - 1);
    localparam logic [3:0]    MAX_R       = 4'(MAX_RETRIES);

    seq_state_t    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    retries_q, retries_nx;
    logic          lock_s;

    logic pll_resetb_q, sys_reset_q, locked_q, fail_q;
    logic pll_resetb_nx, sys_reset_nx, locked_nx, fail_nx;

    pll_seq_sync u_sync (
        .clock (clock),
        .reset (reset),
        .din   (bus.pll_lock),
        .dout  (lock_s)
    );

    // Next state, counter, retry count and the Moore outputs of the next state.
    always_comb begin
        state_nx   = state;
        retries_nx = retries_q;

        case (state)
            ST_PLLRST: begin
                if (cnt == RST_LAST) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (lock_s) begin
                    state_nx = ST_STABLE;
                end else if (cnt == TO_LAST) begin
                    retries_nx = (retries_q == MAX_R) ? retries_q : retries_q + 4'd1;
                    state_nx   = (retries_nx == MAX_R) ? ST_FAIL : ST_PLLRST;
                end
            end
            ST_STABLE: begin
                if (!lock_s)                 state_nx = ST_WAIT;
                else if (cnt == STABLE_LAST) state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                if (!lock_s)               state_nx = ST_WAIT;
                else if (cnt == HOLD_LAST) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) begin
`ifdef PLL_SEQ_RELOCK_EN
                    state_nx   = ST_PLLRST;
                    retries_nx = '0;
`else
                    state_nx   = ST_WAIT;
`endif
                end
            end
            ST_FAIL: begin
                state_nx = ST_FAIL;
            end
            default: begin
                state_nx = ST_PLLRST;
            end
        endcase

        if (state_nx == ST_RUN && state != ST_RUN) retries_nx = '0;

        if (state_nx != state)
            cnt_nx = '0;
        else if (state == ST_RUN || state == ST_FAIL)
            cnt_nx = cnt;
        else
            cnt_nx = cnt + CW'(1);

        // Outputs are decoded from the next state so they register together with it.
        pll_resetb_nx = (state_nx != ST_PLLRST);
        sys_reset_nx  = (state_nx != ST_RUN);
        locked_nx     = (state_nx == ST_RUN);
        fail_nx       = (state_nx == ST_FAIL);
    end

    // State, counter, retry and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_PLLRST;
            cnt          <= '0;
            retries_q    <= '0;
            pll_resetb_q <= 1'b0;
            sys_reset_q  <= 1'b1;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            retries_q    <= retries_nx;
            pll_resetb_q <= pll_resetb_nx;
            sys_reset_q  <= sys_reset_nx;
            locked_q     <= locked_nx;
            fail_q       <= fail_nx;
        end
    end

    assign bus.pll_resetb = pll_resetb_q;
    assign bus.sys_reset  = sys_reset_q;
    assign bus.locked     = locked_q;
    assign bus.fail       = fail_q;
    assign bus.retries    = retries_q;

endmodule
